line_fill_controller: RTL

Sequences line-fill reads from `main_memory` on behalf of two cache requesters: requester 0 is the instruction cache and requester 1 is the data cache. It arbitrates round-robin and aligns the request address to a 16-word line boundary. It then drives the memory address, waits a fixed number of cycles, captures the 512-bit line and returns it with a one-cycle acknowledge. It sits between the cache miss handlers and `main_memory`, and is the only driver of the memory address bus.

---
 rtl/line_fill_controller.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/line_fill_controller.sv
// Line-fill sequencer: round-robin arbitration between the instruction cache (0)
// and data cache (1), line-aligned memory read, fixed-latency capture and one-cycle ack.
module line_fill_controller #(
   parameter int WAIT_CYCLES = 2,
   parameter int CNT_W       = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req0,
   input  logic [31:0]        addr0,
   input  logic               req1,
   input  logic [31:0]        addr1,
   output logic               ack0,
   output logic               ack1,
   output logic [511:0]       line_out,
   output logic               grant,
   output logic               busy,
   output logic [31:0]        mem_addr,
   input  logic [511:0]       mem_data,
   output logic [CNT_W-1:0]   served0,
   output logic [CNT_W-1:0]   served1
);

   localparam int WC_W = $clog2(WAIT_CYCLES + 1);
   localparam logic [WC_W-1:0] WAIT_LOAD = WC_W'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WC_W-1:0]    cnt_q, cnt_d;
   logic [31:0]        mem_addr_q, mem_addr_d;
   logic [511:0]       line_q, line_d;
   logic               grant_q, grant_d;
   logic               last_grant_q, last_grant_d;
   logic               ack0_q, ack0_d;
   logic               ack1_q, ack1_d;
   logic               busy_q, busy_d;
   logic [CNT_W-1:0]   served0_q, served0_d;
   logic [CNT_W-1:0]   served1_q, served1_d;

   logic               sel_valid_s;
   logic               sel_idx_s;
   logic [31:0]        sel_addr_s;
   logic               cnt_last_s;
   logic               unused_addr_bits_s;

   // The low nibble of a miss address never reaches memory: fills are whole lines.
   assign unused_addr_bits_s = ^{addr0[3:0], addr1[3:0]};

   // Round-robin pick: on a tie the requester that was not served last wins.
   always_comb begin
      sel_valid_s = req0 | req1;
      if (req0 && req1) begin
         sel_idx_s = ~last_grant_q;
      end else if (req1) begin
         sel_idx_s = 1'b1;
      end else begin
         sel_idx_s = 1'b0;
      end
      if (sel_idx_s) begin
         sel_addr_s = addr1;
      end else begin
         sel_addr_s = addr0;
      end
      cnt_last_s = (cnt_q == WC_W'(1));
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= {WC_W{1'b0}};
         mem_addr_q   <= 32'h0000_0000;
         line_q       <= {512{1'b0}};
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         busy_q       <= 1'b0;
         served0_q    <= {CNT_W{1'b0}};
         served1_q    <= {CNT_W{1'b0}};
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mem_addr_q   <= mem_addr_d;
         line_q       <= line_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         busy_q       <= busy_d;
         served0_q    <= served0_d;
         served1_q    <= served1_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (sel_valid_s) begin
               state_d = ST_WAIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_last_s) begin
               state_d = ST_RESP;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs; ack is a pulse, everything else holds.
   always_comb begin
      cnt_d        = cnt_q;
      mem_addr_d   = mem_addr_q;
      line_d       = line_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      busy_d       = busy_q;
      served0_d    = served0_q;
      served1_d    = served1_q;
      case (state_q)
         ST_IDLE: begin
            if (sel_valid_s) begin
               mem_addr_d = {sel_addr_s[31:4], 4'b0000};
               grant_d    = sel_idx_s;
               cnt_d      = WAIT_LOAD;
               busy_d     = 1'b1;
            end else begin
               busy_d     = 1'b0;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - WC_W'(1);
            if (cnt_last_s) begin
               line_d = mem_data;
               ack0_d = ~grant_q;
               ack1_d = grant_q;
            end else begin
               line_d = line_q;
            end
         end
         ST_RESP: begin
            busy_d       = 1'b0;
            last_grant_d = grant_q;
            if (grant_q) begin
               served1_d = served1_q + CNT_W'(1);
            end else begin
               served0_d = served0_q + CNT_W'(1);
            end
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   assign ack0     = ack0_q;
   assign ack1     = ack1_q;
   assign line_out = line_q;
   assign grant    = grant_q;
   assign busy     = busy_q;
   assign mem_addr = mem_addr_q;
   assign served0  = served0_q;
   assign served1  = served1_q;

endmodule
